// File: rtl/tictactoe_autoplayer.sv
// Automated tic-tac-toe opponent. It watches the board and its turn flag,
// scans all nine squares one per cycle to pick the best move, presents the
// one-hot selection, presses the button once and holds the selection until
// the controller drops the turn flag. It re-presses on an acknowledge
// timeout and flags a sticky failure when its retries run out.
//
// Handshake: sel_pos is valid from PRESENT until the end of RELEASE; button
// is a single-cycle pulse in PRESS. The controller acknowledges by lowering
// turn, and that is sampled only in WAIT_ACK.
module tictactoe_autoplayer #(
  parameter bit PLAYER       = 1'b0,
  parameter int THINK_CYCLES = 0,
  parameter int ACK_TIMEOUT  = 4,
  parameter int MAX_RETRY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       turn,
  input  logic [8:0] occ_square,
  input  logic [8:0] occ_player,
  output logic [8:0] sel_pos,
  output logic       button,
  output logic       busy,
  output logic [3:0] move_idx,
  output logic       no_move,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_IDLE, S_THINK, S_SCAN, S_PRESENT, S_PRESS, S_WAIT_ACK, S_RELEASE, S_FAIL
  } state_t;

  // Winning lines as square masks: 852, 741, 630, 876, 543, 210, 840, 642.
  localparam logic [8:0] TREYS [8] = '{
    9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007, 9'h111, 9'h054
  };
  localparam logic [8:0] CORNERS    = 9'h145;
  localparam logic [7:0] THINK_LAST = THINK_CYCLES[7:0] - 8'd1;
  localparam logic [3:0] ACK_LAST   = ACK_TIMEOUT[3:0] - 4'd1;
  localparam logic [7:0] RETRY_MAX  = MAX_RETRY[7:0];

  state_t     state;
  state_t     next_state;
  logic [7:0] think_cnt;
  logic [3:0] ack_cnt;
  logic [7:0] retry_cnt;
  logic [3:0] scan_idx;
  logic [3:0] best_idx;
  logic [2:0] best_rank;
  logic       best_found;

  logic [8:0] mine;
  logic [8:0] opp;
  logic [8:0] cand_bit;
  logic       cand_free;
  logic [2:0] cand_rank;
  logic       take;
  logic [3:0] final_idx;
  logic       final_found;

  // True when adding the candidate square to 'side' fills a whole line
  // that passes through the candidate.
  function automatic logic completes(input logic [8:0] side, input logic [8:0] cand);
    logic [8:0] with_c;
    logic       hit;
    with_c = side | cand;
    hit    = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (((TREYS[t] & cand) != 9'b0) && ((with_c & TREYS[t]) == TREYS[t])) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  assign mine = occ_square & (PLAYER ? occ_player : ~occ_player);
  assign opp  = occ_square & ~mine;
  assign busy = (state != S_IDLE) && (state != S_FAIL);

  // Rank the current scan candidate and fold it into the running best.
  always_comb begin
    cand_bit  = 9'b1 << scan_idx;
    cand_free = (occ_square & cand_bit) == 9'b0;
    cand_rank = 3'd0;
    if (completes(mine, cand_bit)) begin
      cand_rank = 3'd4;
    end else if (completes(opp, cand_bit)) begin
      cand_rank = 3'd3;
    end else if (scan_idx == 4'd4) begin
      cand_rank = 3'd2;
    end else if ((cand_bit & CORNERS) != 9'b0) begin
      cand_rank = 3'd1;
    end
    // Strictly-greater keeps the earlier (higher) index on ties.
    take        = cand_free && (!best_found || (cand_rank > best_rank));
    final_idx   = take ? scan_idx : best_idx;
    final_found = best_found | take;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; enable is honoured only up to PRESENT.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (enable && turn) begin
          next_state = (THINK_CYCLES == 0) ? S_SCAN : S_THINK;
        end
      end
      S_THINK: begin
        if (!enable) begin
          next_state = S_IDLE;
        end else if (think_cnt == THINK_LAST) begin
          next_state = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!enable) begin
          next_state = S_IDLE;
        end else if (scan_idx == 4'd0) begin
          next_state = final_found ? S_PRESENT : S_IDLE;
        end
      end
      S_PRESENT: begin
        next_state = enable ? S_PRESS : S_IDLE;
      end
      S_PRESS: begin
        next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!turn) begin
          next_state = S_RELEASE;
        end else if (ack_cnt == ACK_LAST) begin
          next_state = (retry_cnt < RETRY_MAX) ? S_SCAN : S_FAIL;
        end
      end
      S_RELEASE: begin
        next_state = S_IDLE;
      end
      S_FAIL: begin
        if (!turn) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Counters, scan bookkeeping and registered outputs, all driven from
  // the upcoming state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      think_cnt  <= 8'd0;
      ack_cnt    <= 4'd0;
      retry_cnt  <= 8'd0;
      scan_idx   <= 4'd0;
      best_idx   <= 4'd0;
      best_rank  <= 3'd0;
      best_found <= 1'b0;
      sel_pos    <= 9'b0;
      button     <= 1'b0;
      move_idx   <= 4'hF;
      no_move    <= 1'b0;
      fail       <= 1'b0;
    end else begin
      think_cnt <= (state == S_THINK) ? think_cnt + 8'd1 : 8'd0;
      ack_cnt   <= (state == S_WAIT_ACK) ? ack_cnt + 4'd1 : 4'd0;

      if ((state != S_SCAN) && (next_state == S_SCAN)) begin
        scan_idx   <= 4'd8;
        best_idx   <= 4'd0;
        best_rank  <= 3'd0;
        best_found <= 1'b0;
      end else if (state == S_SCAN) begin
        scan_idx <= scan_idx - 4'd1;
        if (take) begin
          best_idx   <= scan_idx;
          best_rank  <= cand_rank;
          best_found <= 1'b1;
        end
      end

      if ((state == S_WAIT_ACK) && (next_state == S_SCAN)) begin
        retry_cnt <= retry_cnt + 8'd1;
      end else if (next_state == S_IDLE) begin
        retry_cnt <= 8'd0;
      end

      if ((state == S_SCAN) && (next_state == S_PRESENT)) begin
        sel_pos  <= 9'b1 << final_idx;
        move_idx <= final_idx;
      end else if (!(next_state inside {S_PRESENT, S_PRESS, S_WAIT_ACK, S_RELEASE})) begin
        sel_pos <= 9'b0;
      end

      button  <= (next_state == S_PRESS);
      no_move <= (state == S_SCAN) && enable && (scan_idx == 4'd0) && !final_found;
      fail    <= (next_state == S_FAIL);
    end
  end

endmodule
